// File: rtl/tokenizer_pkg.sv
// tokenizer_pkg
// Shared types and helpers for the FIND front end: the tokenizer state
// encoding, the delimiter threshold, and the byte classification and
// case-folding helpers used while copying a token.
// No ports (package).
package tokenizer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        S_RD,
        S_CHK,
        C_RD,
        C_CHK,
        LEN,
        DONE
    } tok_sts;

    // Any byte at or below this value (space and all control codes) separates tokens.
    localparam logic [7:0] DELIM = 8'h20;

    function automatic logic is_delim(input logic [7:0] b);
        return (b <= DELIM);
    endfunction

    function automatic logic [7:0] to_upper(input logic [7:0] b);
        if (b >= 8'h61 && b <= 8'h7A)
            return b - 8'h20;
        return b;
    endfunction

endpackage

// File: rtl/tokenizer.sv
// tokenizer
// Scans the terminal input buffer from >IN, skips leading delimiters and
// copies the next token into a counted string (length byte at dst, text at
// dst+1..). Reports the string address and the updated >IN so FIND can run
// on the token directly. Masters an external single-port byte memory with
// one cycle of read latency.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               begin a scan (sampled only in IDLE)
//   tib, ntib, in_i     TIB base, valid byte count, starting >IN
//   dst                 counted-string buffer address
//   mem_a/mem_we/mem_vo memory address, write enable, write data
//   mem_vi              memory read data (valid one cycle after mem_a)
//   bsy, done           scanning flag, one-cycle result strobe
//   eol, ovf, len       no token found, token truncated, stored length
//   in_o, ao            updated >IN, counted-string address
module tokenizer
    import tokenizer_pkg::*;
#(
    parameter int DSZ    = 8,
    parameter int ASZ    = 17,
    parameter int ISZ    = 8,
    parameter int MAXLEN = 31,
    parameter int UPPER  = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [ASZ-1:0] tib,
    input  logic [ISZ-1:0] ntib,
    input  logic [ISZ-1:0] in_i,
    input  logic [ASZ-1:0] dst,
    output logic [ASZ-1:0] mem_a,
    output logic           mem_we,
    output logic [DSZ-1:0] mem_vo,
    input  logic [DSZ-1:0] mem_vi,
    output logic           bsy,
    output logic           done,
    output logic           eol,
    output logic           ovf,
    output logic [DSZ-1:0] len,
    output logic [ISZ-1:0] in_o,
    output logic [ASZ-1:0] ao
);

    localparam logic [DSZ-1:0] MAXLEN_C = DSZ'(MAXLEN);
    localparam logic [ASZ-1:0] ONE_A    = ASZ'(1);

    tok_sts         state_q, state_d;
    logic [ASZ-1:0] tib_q, tib_d;
    logic [ASZ-1:0] dst_q, dst_d;
    logic [ISZ-1:0] ntib_q, ntib_d;
    logic [ISZ-1:0] ptr_q, ptr_d;
    logic [DSZ-1:0] cnt_q, cnt_d;
    logic           trunc_q, trunc_d;

    logic           bsy_q, bsy_d;
    logic           done_q, done_d;
    logic           eol_q, eol_d;
    logic           ovf_q, ovf_d;
    logic [DSZ-1:0] len_q, len_d;
    logic [ISZ-1:0] in_o_q, in_o_d;
    logic [ASZ-1:0] ao_q, ao_d;

    logic [ASZ-1:0] mem_a_d;
    logic           mem_we_d;
    logic [DSZ-1:0] mem_vo_d;
    logic [DSZ-1:0] folded;

    assign folded = (UPPER != 0) ? to_upper(mem_vi) : mem_vi;

    always_comb begin
        state_d  = state_q;
        tib_d    = tib_q;
        dst_d    = dst_q;
        ntib_d   = ntib_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        trunc_d  = trunc_q;
        bsy_d    = bsy_q;
        done_d   = 1'b0;
        eol_d    = eol_q;
        ovf_d    = ovf_q;
        len_d    = len_q;
        in_o_d   = in_o_q;
        ao_d     = ao_q;
        mem_a_d  = '0;
        mem_we_d = 1'b0;
        mem_vo_d = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    tib_d   = tib;
                    ntib_d  = ntib;
                    dst_d   = dst;
                    ptr_d   = in_i;
                    cnt_d   = '0;
                    trunc_d = 1'b0;
                    bsy_d   = 1'b1;
                    state_d = S_RD;
                end
            end
            S_RD, C_RD: begin
                if (ptr_q >= ntib_q) begin
                    state_d = LEN;
                end else begin
                    mem_a_d = tib_q + ASZ'(ptr_q);
                    state_d = (state_q == S_RD) ? S_CHK : C_CHK;
                end
            end
            S_CHK, C_CHK: begin
                // The read data is already on mem_vi, so the port is free for the copy write.
                ptr_d = ptr_q + ISZ'(1);
                if (is_delim(mem_vi)) begin
                    state_d = (state_q == S_CHK) ? S_RD : LEN;
                end else begin
                    if (cnt_q < MAXLEN_C) begin
                        mem_we_d = 1'b1;
                        mem_a_d  = dst_q + ONE_A + ASZ'(cnt_q);
                        mem_vo_d = folded;
                        cnt_d    = cnt_q + DSZ'(1);
                    end else begin
                        // Excess characters are still consumed from the TIB, just not stored.
                        trunc_d = 1'b1;
                    end
                    state_d = C_RD;
                end
            end
            LEN: begin
                mem_we_d = 1'b1;
                mem_a_d  = dst_q;
                mem_vo_d = cnt_q;
                bsy_d    = 1'b0;
                done_d   = 1'b1;
                len_d    = cnt_q;
                in_o_d   = ptr_q;
                ao_d     = dst_q;
                eol_d    = (cnt_q == '0);
                ovf_d    = trunc_q;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tib_q   <= '0;
            dst_q   <= '0;
            ntib_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            trunc_q <= 1'b0;
            bsy_q   <= 1'b0;
            done_q  <= 1'b0;
            eol_q   <= 1'b0;
            ovf_q   <= 1'b0;
            len_q   <= '0;
            in_o_q  <= '0;
            ao_q    <= '0;
        end else begin
            tib_q   <= tib_d;
            dst_q   <= dst_d;
            ntib_q  <= ntib_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            trunc_q <= trunc_d;
            bsy_q   <= bsy_d;
            done_q  <= done_d;
            eol_q   <= eol_d;
            ovf_q   <= ovf_d;
            len_q   <= len_d;
            in_o_q  <= in_o_d;
            ao_q    <= ao_d;
        end
    end

    // A reset arriving mid-copy must not let the in-flight write land.
    assign mem_we = mem_we_d & ~rst;
    assign mem_a  = mem_a_d;
    assign mem_vo = mem_vo_d;

    assign bsy  = bsy_q;
    assign done = done_q;
    assign eol  = eol_q;
    assign ovf  = ovf_q;
    assign len  = len_q;
    assign in_o = in_o_q;
    assign ao   = ao_q;

endmodule
